seg_pipe_adder: RTL and testbench

SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

---
 rtl/seg_pipe_adder.sv | 167 ++++++++++++++++
 tb/tb_seg_pipe_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: segmented ripple-carry adder, SEG bits resolved per stage,
// NSTG = WIDTH/SEG stages followed by an output register with valid/ready
// handshake. Whole pipeline freezes while the output is stalled.
// Optional feature macro: SEG_PIPE_ADDER_SAT_EN (saturate sum to all ones on
// final carry; cout still reports the overflow).
module seg_pipe_adder #(
  parameter int WIDTH = 10,
  parameter int SEG   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
  localparam int NSTG     = (WIDTH / SEG_SAFE < 1) ? 1 : WIDTH / SEG_SAFE;

  if ((WIDTH < 1) || (SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_params
    $error("seg_pipe_adder: WIDTH must be >= 1 and a multiple of SEG >= 1");
  end

`ifdef SEG_PIPE_ADDER_SAT_EN
  // Clamp the sum to all ones when the final carry is set.
  function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] s, input logic c);
    logic [WIDTH-1:0] r;
    if (c) begin
      r = {WIDTH{1'b1}};
    end else begin
      r = s;
    end
    return r;
  endfunction
`endif

  logic             stall_s;
  logic [NSTG-1:0]  vld_s;
  logic             last_vld_s;
  logic             last_cry_s;
  logic [WIDTH-1:0] last_acc_s;
  logic [WIDTH-1:0] fin_sum_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  // A held, unconsumed result freezes every register in the pipe.
  assign stall_s = out_valid_r & ~out_ready;

  for (genvar g = 0; g < NSTG; g++) begin : stg
    localparam int BASE = g * SEG_SAFE;
    localparam int LO   = BASE + SEG_SAFE;
    localparam int HI   = WIDTH - LO;

    // acc_r holds finished sum bits [LO-1:0] and untouched a bits above them.
    logic             vld_r;
    logic             cry_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_in_s;
    logic [WIDTH-1:0] acc_d_s;
    logic [SEG_SAFE-1:0] bseg_s;
    logic             c_s;
    logic             v_s;
    logic [SEG_SAFE:0] add_s;

    if (g == 0) begin : src
      assign acc_in_s = a;
      assign bseg_s   = b[SEG_SAFE-1:0];
      assign c_s      = cin;
      assign v_s      = in_valid & in_ready;
    end else begin : src
      assign acc_in_s = stg[g-1].acc_r;
      assign bseg_s   = stg[g-1].bh.bhi_r[SEG_SAFE-1:0];
      assign c_s      = stg[g-1].cry_r;
      assign v_s      = stg[g-1].vld_r;
    end

    // Upper b bits not yet consumed travel alongside the stage.
    if (HI > 0) begin : bh
      logic [HI-1:0] bhi_r;
      logic [HI-1:0] bhi_d_s;
      if (g == 0) begin : bsrc
        assign bhi_d_s = b[WIDTH-1:LO];
      end else begin : bsrc
        assign bhi_d_s = stg[g-1].bh.bhi_r[HI+SEG_SAFE-1:SEG_SAFE];
      end

      // Delay register for the remaining b bits; data need not clear on flush.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bhi_r <= {HI{1'b0}};
        end else if (!stall_s) begin
          bhi_r <= bhi_d_s;
        end
      end
    end

    assign add_s = {1'b0, acc_in_s[BASE +: SEG_SAFE]} + {1'b0, bseg_s}
                 + {{SEG_SAFE{1'b0}}, c_s};

    // Splice this segment's sum bits into the travelling accumulator.
    always_comb begin
      acc_d_s = acc_in_s;
      acc_d_s[BASE +: SEG_SAFE] = add_s[SEG_SAFE-1:0];
    end

    // Stage register: valid bit, segment carry and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= 1'b0;
        cry_r <= 1'b0;
        acc_r <= {WIDTH{1'b0}};
      end else if (flush) begin
        vld_r <= 1'b0;
      end else if (!stall_s) begin
        vld_r <= v_s;
        cry_r <= add_s[SEG_SAFE];
        acc_r <= acc_d_s;
      end
    end

    assign vld_s[g] = vld_r;
  end

  assign last_vld_s = stg[NSTG-1].vld_r;
  assign last_cry_s = stg[NSTG-1].cry_r;
  assign last_acc_s = stg[NSTG-1].acc_r;

`ifdef SEG_PIPE_ADDER_SAT_EN
  assign fin_sum_s = sat_fn(last_acc_s, last_cry_s);
`else
  assign fin_sum_s = last_acc_s;
`endif

  // Output register: takes the last-stage result whenever not stalled, so a
  // consumed result is replaced in the same edge without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (!stall_s) begin
      out_valid_r <= last_vld_s;
      if (last_vld_s) begin
        sum_r  <= fin_sum_s;
        cout_r <= last_cry_s;
      end
    end
  end

  assign in_ready  = ~stall_s & ~flush;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign busy      = (|vld_s) | out_valid_r;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder (WIDTH=10, SEG=5, two stages).
module tb_seg_pipe_adder;

  localparam int WIDTH = 10;
  localparam int SEG   = 5;
  localparam int NSTG  = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] q[$];
  logic [WIDTH:0] exp_v;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             c;
  } vec_t;
  vec_t vt[7];

  always #5 clk = ~clk;

  seg_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  // Reference: plain integer addition, then wrap or clamp.
  function automatic logic [WIDTH:0] ref_sum(input int x, input int y, input int c);
    int t;
    logic [WIDTH:0] r;
    t = x + y + c;
    r = (WIDTH+1)'(t);
`ifdef SEG_PIPE_ADDER_SAT_EN
    if (t >= (1 << WIDTH)) r = {1'b1, {WIDTH{1'b1}}};
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted op must come out once, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!(out_valid && !out_ready) && !flush)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got sum %0d cout %0d expected none", sum, cout);
        end else begin
          exp_v = q.pop_front();
          chk("result", {21'd0, cout, sum}, {21'd0, exp_v});
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(ref_sum(int'(a), int'(b), int'(cin)));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    int runs;
    int idx;
    logic prev_ov;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] got;

    vt[0] = '{10'd300,  10'd200,  1'b1, 10'd501,  1'b0};
`ifdef SEG_PIPE_ADDER_SAT_EN
    vt[1] = '{10'd1023, 10'd1,    1'b0, 10'd1023, 1'b1};
    vt[4] = '{10'd512,  10'd511,  1'b1, 10'd1023, 1'b1};
`else
    vt[1] = '{10'd1023, 10'd1,    1'b0, 10'd0,    1'b1};
    vt[4] = '{10'd512,  10'd511,  1'b1, 10'd0,    1'b1};
`endif
    vt[2] = '{10'd1023, 10'd1023, 1'b1, 10'd1023, 1'b1};
    vt[3] = '{10'd0,    10'd0,    1'b0, 10'd0,    1'b0};
    vt[5] = '{10'd341,  10'd682,  1'b0, 10'd1023, 1'b0};
    vt[6] = '{10'd5,    10'd6,    1'b0, 10'd11,   1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {22'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Single ops: latency, busy and values.
    for (int i = 0; i < 7; i++) begin
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_e0_ov", {31'd0, out_valid}, 32'd0);
      chk("lat_e0_busy", {31'd0, busy}, 32'd1);
      step();
      chk("lat_e1_ov", {31'd0, out_valid}, 32'd0);
      chk("lat_e1_busy", {31'd0, busy}, 32'd1);
      step();
      chk("lat_e2_ov", {31'd0, out_valid}, 32'd1);
      chk("vec_sum", {22'd0, sum}, {22'd0, vt[i].s});
      chk("vec_cout", {31'd0, cout}, {31'd0, vt[i].c});
      step();
      chk("drained_ov", {31'd0, out_valid}, 32'd0);
      chk("drained_busy", {31'd0, busy}, 32'd0);
    end

    // Back-to-back: 8 ops, 8 consecutive valid cycles.
    seen = 0; runs = 0; prev_ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 8);
      a = WIDTH'(i * 100); b = WIDTH'(i); cin = i[0];
      #1;
      if (i < 8) chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      step();
      if (out_valid) seen++;
      if (out_valid && !prev_ov) runs++;
      prev_ov = out_valid;
    end
    in_valid = 1'b0;
    chk("b2b_count", seen, 32'd8);
    chk("b2b_runs", runs, 32'd1);

    // Stall for 5 cycles while streaming.
    idx = 0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (idx < 8);
      a = WIDTH'(37 * idx + 900); b = WIDTH'(11 * idx + 3); cin = idx[0];
      out_ready = !(c >= 4 && c < 9);
      #1;
      if (c >= 4 && c < 9) begin
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_ov", {31'd0, out_valid}, 32'd1);
        if (c == 4) held = sum;
        else chk("stall_sum_hold", {22'd0, sum}, {22'd0, held});
      end
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_all_sent", idx, 32'd8);
    chk("stall_q_empty", q.size(), 32'd0);

    // Flush with two ops in flight, and a simultaneous offer.
    a = 10'd7; b = 10'd8; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 10'd9; b = 10'd10; cin = 1'b1;
    step();
    a = 10'd1; b = 10'd1; flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_ov", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    a = 10'd5; b = 10'd6; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    seen = 0; got = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) begin seen++; got = sum; end
    end
    chk("flush_one_result", seen, 32'd1);
    chk("flush_sum11", {22'd0, got}, 32'd11);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      a = WIDTH'(100 + i); b = WIDTH'(200 + i); cin = 1'b1; in_valid = 1'b1;
      step();
    end
    chk("pre_rst_ov", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    q.delete();
    #1;
    chk("arst_ov", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_sum", {22'd0, sum}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (NSTG + 4) step();
    chk("rand_q_empty", q.size(), 32'd0);
    chk("rand_idle_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
